// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution unit: condition codes, flag layout, FlagW bit positions.
// Latency: none (types and constants only).
// Backpressure: none.
package cond_pkg;

  // ARM condition field encodings; NV (4'b1111) is the reserved code.
  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  // Bit order matches the ALUFlags bus: {N,Z,C,V}.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // FlagW bit indices.
  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_eval.sv
// Evaluates an ARM condition field against one NZCV value.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
//
// Ports:
//   i_cond      condition field
//   i_flags     NZCV of the selected context
//   o_cond_ex   condition passed
//   o_reserved  condition field is the reserved code
module cond_eval
  import cond_pkg::*;
(
  input  cond_e i_cond,
  input  nzcv_t i_flags,
  output logic  o_cond_ex,
  output logic  o_reserved
);

  logic w_ge;

  assign w_ge = (i_flags.n == i_flags.v);

  always_comb begin
    o_cond_ex  = 1'b0;
    o_reserved = 1'b0;
    case (i_cond)
      EQ: o_cond_ex = i_flags.z;
      NE: o_cond_ex = ~i_flags.z;
      CS: o_cond_ex = i_flags.c;
      CC: o_cond_ex = ~i_flags.c;
      MI: o_cond_ex = i_flags.n;
      PL: o_cond_ex = ~i_flags.n;
      VS: o_cond_ex = i_flags.v;
      VC: o_cond_ex = ~i_flags.v;
      HI: o_cond_ex = i_flags.c & ~i_flags.z;
      LS: o_cond_ex = ~i_flags.c | i_flags.z;
      GE: o_cond_ex = w_ge;
      LT: o_cond_ex = ~w_ge;
      GT: o_cond_ex = ~i_flags.z & w_ge;
      LE: o_cond_ex = i_flags.z | ~w_ge;
      AL: o_cond_ex = 1'b1;
      NV: begin
        o_cond_ex  = 1'b0;
        o_reserved = 1'b1;
      end
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_ctx_unit.sv
// Multi-context NZCV holder with condition gating of PCSrc/RegWrite/MemWrite and per-context flag save stacks.
// Latency: gating, CondEx, flags 0 cycles; flag update/push/pop at next edge; illegal/stack_err one cycle later.
// Backpressure: none; overflow/underflow/conflicting push+pop are dropped and flagged on stack_err.
//
// Ports:
//   clk, reset             clock, async active-low reset
//   ex_valid, ctx_sel      instruction valid, context of instruction and push/pop
//   Cond, ALUFlags, FlagW  condition field, ALU NZCV, flag write enables ([1] NZ, [0] CV)
//   PCS, RegW, MemW, NoWrite  decoder intents
//   push, pop              save / restore selected context's flags
//   PCSrc, RegWrite, MemWrite, CondEx  gated controls and raw condition pass
//   flags, stack_cnt       selected context's current NZCV and stack occupancy
//   illegal, stack_err     registered one-cycle error pulses
module cond_ctx_unit
  import cond_pkg::*;
#(
  parameter int NCTX  = 4,
  parameter int DEPTH = 4,
  parameter int CTXW  = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ex_valid,
  input  logic [CTXW-1:0]            ctx_sel,
  input  logic [3:0]                 Cond,
  input  logic [3:0]                 ALUFlags,
  input  logic [1:0]                 FlagW,
  input  logic                       PCS,
  input  logic                       RegW,
  input  logic                       MemW,
  input  logic                       NoWrite,
  input  logic                       push,
  input  logic                       pop,
  output logic                       PCSrc,
  output logic                       RegWrite,
  output logic                       MemWrite,
  output logic                       CondEx,
  output logic [3:0]                 flags,
  output logic [$clog2(DEPTH+1)-1:0] stack_cnt,
  output logic                       illegal,
  output logic                       stack_err
);

  localparam int CNTW  = $clog2(DEPTH + 1);
  // Stack slots are rounded up to a power of two so the slot index has an exact width.
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IDXW;

  nzcv_t           r_flags [NCTX];
  logic [CNTW-1:0] r_cnt   [NCTX];
  nzcv_t           r_stack [NCTX][SLOTS];
  logic            r_illegal;
  logic            r_stack_err;

  nzcv_t           w_cur;
  nzcv_t           w_top;
  nzcv_t           w_nxt;
  logic [CNTW-1:0] w_cnt;
  logic [IDXW-1:0] w_push_idx;
  logic [IDXW-1:0] w_pop_idx;
  logic            w_full;
  logic            w_empty;
  logic            w_push_ok;
  logic            w_pop_ok;
  logic            w_err;
  logic            w_cond_ex;
  logic            w_reserved;
  logic            w_ce;

  assign w_cur      = r_flags[ctx_sel];
  assign w_cnt      = r_cnt[ctx_sel];
  assign w_full     = (w_cnt == CNTW'(DEPTH));
  assign w_empty    = (w_cnt == '0);
  assign w_push_idx = IDXW'(w_cnt);
  assign w_pop_idx  = IDXW'(w_cnt - CNTW'(1));
  assign w_top      = r_stack[ctx_sel][w_pop_idx];

  // Push and pop in the same cycle cancel each other and are reported.
  assign w_push_ok  = push & ~pop & ~w_full;
  assign w_pop_ok   = pop & ~push & ~w_empty;
  assign w_err      = (push & pop) | (push & ~pop & w_full) | (pop & ~push & w_empty);

  cond_eval u_eval (
    .i_cond     (cond_e'(Cond)),
    .i_flags    (w_cur),
    .o_cond_ex  (w_cond_ex),
    .o_reserved (w_reserved)
  );

  assign w_ce     = w_cond_ex & ex_valid;
  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS & w_ce;
  assign MemWrite = MemW & w_ce;
  assign RegWrite = RegW & w_ce & ~NoWrite;

  // Next NZCV of the selected context; a successful pop wins over the ALU write.
  always_comb begin
    w_nxt = w_cur;
    if (FlagW[FW_NZ] & w_ce) begin
      w_nxt.n = ALUFlags[3];
      w_nxt.z = ALUFlags[2];
    end
    if (FlagW[FW_CV] & w_ce) begin
      w_nxt.c = ALUFlags[1];
      w_nxt.v = ALUFlags[0];
    end
    if (w_pop_ok) begin
      w_nxt = w_top;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCTX; i++) begin
        r_flags[i] <= '0;
        r_cnt[i]   <= '0;
      end
      r_illegal   <= 1'b0;
      r_stack_err <= 1'b0;
    end else begin
      r_flags[ctx_sel] <= w_nxt;
      if (w_push_ok) begin
        r_cnt[ctx_sel] <= w_cnt + CNTW'(1);
      end else if (w_pop_ok) begin
        r_cnt[ctx_sel] <= w_cnt - CNTW'(1);
      end
      r_illegal   <= w_reserved & ex_valid;
      r_stack_err <= w_err;
    end
  end

  // Stack contents need no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_stack[ctx_sel][w_push_idx] <= w_cur;
    end
  end

  assign flags     = w_cur;
  assign stack_cnt = w_cnt;
  assign illegal   = r_illegal;
  assign stack_err = r_stack_err;

endmodule

// File: doc/cond_ctx_unit.md
# cond_ctx_unit

Multi-context conditional-execution unit for the ARM core. Holds one NZCV flag register per hardware context, evaluates the 4-bit condition field of the current instruction against the selected context's flags, and gates PCSrc/RegWrite/MemWrite. It sits between the decoder and the register file/memory-write/PC-select logic. It adds per-context flag save/restore stacks for exception entry and return, a defined response to the reserved condition code, and an explicit instruction-valid qualifier.

## Interface
- NCTX, default 4: number of flag contexts; must be ≥1.
- DEPTH, default 4: save-stack entries per context; must be ≥1.
- CTXW, default $clog2(NCTX) (1 when NCTX=1): derived width of the context select.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  current instruction is valid. When low, the instruction has no architectural effect.
- ctx_sel  in  CTXW  context of the current instruction and of push/pop.
- Cond  in  4  instruction condition field.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- FlagW  in  2  [1] writes N,Z; [0] writes C,V.
- PCS, RegW, MemW, NoWrite  in  1 each  decoder intents.
- push  in  1  save the selected context's flags onto its stack.
- pop  in  1  restore the selected context's flags from its stack.
- PCSrc, RegWrite, MemWrite  out  1 each  gated write controls.
- CondEx  out  1  condition passed.
- flags  out  4  current NZCV of ctx_sel (registered value, before this cycle's update).
- stack_cnt  out  $clog2(DEPTH+1)  occupancy of ctx_sel's stack.
- illegal  out  1  registered pulse: reserved condition executed.
- stack_err  out  1  registered pulse: overflow, underflow, or push and pop together.

## Operation
- Condition evaluation is combinational over flags[ctx_sel]:
  - EQ/NE, CS/CC, MI/PL, VS/VC, HI/LS, GE/LT, GT/LE, AL follow ARM semantics, with ge = (N==V).
  - Cond=4'b1111 (reserved) gives CondEx=0, and illegal is set for one cycle when ex_valid=1.
- Qualified pass: ce = CondEx & ex_valid.
  - PCSrc = PCS & ce.
  - MemWrite = MemW & ce.
  - RegWrite = RegW & ce & ~NoWrite.
- Flag update at the clock edge, for context ctx_sel only:
  - N,Z ← ALUFlags[3:2] if FlagW[1] & ce.
  - C,V ← ALUFlags[1:0] if FlagW[0] & ce.
  - Other contexts hold.
- Push (push=1, pop=0):
  - If cnt<DEPTH: writes the pre-update flags[ctx_sel] to entry cnt and increments cnt.
  - If full: no change, stack_err=1.
  - A flag update in the same cycle still occurs.
- Pop (pop=1, push=0):
  - If cnt>0: flags[ctx_sel] ← entry cnt-1 and decrements cnt.
  - Pop overrides any same-cycle FlagW update to that context.
  - If empty: no change, stack_err=1, and the normal flag update still applies.
- push=1 and pop=1 together: both ignored, stack_err=1, normal flag update applies.
- Push and pop are independent of ex_valid and Cond.

## Timing
- Gated controls, CondEx and flags: 0-cycle combinational from inputs and registered state.
- Flag update, push and pop take effect at the next rising edge. The instruction in the following cycle sees the new value.
- illegal and stack_err assert in the cycle after the causing edge, for exactly one cycle.
- Reset (asynchronous, any time, including mid-push/pop):
  - All flags = 4'b0000 and all cnt = 0.
  - illegal = 0 and stack_err = 0.
  - Stack entry contents are don't-care.
- Outputs during reset follow the combinational rules with the flags at zero.
- A context switch (ctx_sel change) needs no dead cycle.

## Structure
- Package cond_pkg holds:
  - The cond_e enum: EQ..AL and NV=4'b1111.
  - The nzcv_t packed struct {n,z,c,v}.
  - Localparams for the FlagW bit indices.
- Sub-module cond_eval: combinational (cond_e, nzcv_t) → {CondEx, reserved}. It is instantiated once, on the selected context.
- Top level holds:
  - The NCTX flag registers.
  - NCTX×DEPTH stack storage.
  - The per-context counters.
  - The error/illegal pulse flops.

## Test plan
- Reset, then NCTX=4 and ctx_sel=2:
  - Cond=EQ → CondEx=0.
  - FlagW=2'b11, ALUFlags=4'b0100, Cond=AL, ex_valid=1 → next cycle Cond=EQ gives CondEx=1 and flags=4'b0100.
  - ctx 0 flags remain 0.
- All 15 defined conditions against all 16 NZCV values, plus Cond=4'b1111:
  - CondEx matches the ARM table.
  - 4'b1111 gives CondEx=0 and a one-cycle illegal pulse.
- ex_valid=0 with PCS=RegW=MemW=1, Cond=AL, FlagW=2'b11 → all gated outputs 0 and flags unchanged.
- Stack, DEPTH=4:
  - Push 5 times on ctx 1 with distinct flags → cnt=4, and stack_err on the 5th.
  - Pop 4 times → values restored in LIFO order.
  - A 5th pop → stack_err with flags unchanged.
- Same cycle pop plus FlagW=2'b11 with ALUFlags=4'b1111, top of stack = 4'b0010 → flags=4'b0010 next cycle.
- Same cycle push and pop → stack_err=1 and cnt unchanged.
- Assert reset low mid-sequence with cnt=3 → cnt=0, flags=0 and pulses cleared, immediately and asynchronously.
